// File: rtl/sync_fifo.sv
// Single-clock FIFO: circular buffer with registered read data and
// occupancy-derived empty/full flags. No fall-through: a word written on an
// edge is visible to reads from the following edge onward.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic rd_accept;
  logic wr_accept;

  // Accept decode; a read on the same edge frees the slot a full write needs.
  always_comb begin
    rd_accept = rd_en && (count_q != '0);
    wr_accept = wr_en && ((count_q != FullCnt) || rd_accept);
  end

  // Next-state for pointers, occupancy and read data.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; not cleared by reset, but reset blocks a concurrent write.
  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Flags decoded from the registered count only.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FullCnt);
    rd_data = rd_data_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model compared on
// every falling edge, plus directed literal checks for the key scenarios.
module tb_sync_fifo;

  localparam int unsigned W = 8;
  localparam int unsigned D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] wr_data;
  logic [W-1:0] rd_data;
  logic         empty;
  logic         full;

  sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .empty  (empty),
    .full   (full)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_rd;
  bit           model_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one edge worth of inputs and advance the reference model.
  task automatic cycle(input logic r_n, input logic w, input logic r, input logic [W-1:0] d);
    bit rd_ok;
    bit wr_ok;
    rst     = r_n;
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    @(posedge clk);
    if (!r_n) begin
      model_q.delete();
      exp_rd = '0;
    end else begin
      rd_ok = r && (model_q.size() > 0);
      wr_ok = w && ((model_q.size() < D) || rd_ok);
      if (rd_ok) exp_rd = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
    end
    model_ok = 1'b1;
    #1;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("rd_data", 32'(rd_data), 32'(exp_rd));
      chk("empty", 32'(empty), 32'(model_q.size() == 0));
      chk("full", 32'(full), 32'(model_q.size() == D));
    end
  end

  initial begin
    int unsigned wcnt;

    // Reset with both enables high: nothing written.
    cycle(1'b0, 1'b1, 1'b1, 8'h33);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    chk("post_reset_nothing_written", 32'(empty), 32'd1);
    chk("post_reset_rd_hold", 32'(rd_data), 32'h0);

    // Basic ordering.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b1, 1'b0, W'(i));
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    chk("basic_rd1", 32'(rd_data), 32'h1);
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    chk("basic_rd2", 32'(rd_data), 32'h2);
    chk("basic_not_empty", 32'(empty), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 8'h04);
    cycle(1'b1, 1'b1, 1'b0, 8'h05);
    for (int i = 3; i <= 5; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'h00);
      chk("basic_drain", 32'(rd_data), 32'(i));
    end
    chk("basic_empty_after", 32'(empty), 32'd1);

    // Fill to full, drop a write, then simultaneous read/write at full.
    for (int i = 0; i < 16; i++) begin
      chk("fill_not_full", 32'(full), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, W'(i));
    end
    chk("full_set", 32'(full), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 8'hAA);
    chk("full_drop_keeps_full", 32'(full), 32'd1);
    cycle(1'b1, 1'b1, 1'b1, 8'h55);
    chk("full_simul_oldest", 32'(rd_data), 32'h0);
    chk("full_simul_stays_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'h00);
      chk("full_drain", 32'(rd_data), (i < 15) ? 32'(i + 1) : 32'h55);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Reads while empty hold data; simultaneous at empty writes only.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 8'h00);
    chk("empty_rd_hold", 32'(rd_data), 32'h55);
    cycle(1'b1, 1'b1, 1'b1, 8'h77);
    chk("empty_simul_not_empty", 32'(empty), 32'd0);
    chk("empty_simul_rd_hold", 32'(rd_data), 32'h55);
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    chk("empty_then_read", 32'(rd_data), 32'h77);
    chk("empty_then_read_empty", 32'(empty), 32'd1);

    // Random stream with wrap-around; reset mid-stream.
    wcnt = 0;
    for (int c = 0; c < 200; c++) begin
      logic w;
      logic r;
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0) || (c >= 120);
      if (c == 60) begin
        cycle(1'b0, w, r, W'($urandom));
        chk("midstream_reset_empty", 32'(empty), 32'd1);
        chk("midstream_reset_rd", 32'(rd_data), 32'h0);
      end else begin
        cycle(1'b1, w && (c < 120), r, W'(8'h80 + wcnt));
        if (w && (c < 120)) wcnt++;
      end
    end
    chk("stream_final_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
